// File: rtl/dfb_cfg_pkg.sv
// Shared definitions for the SPI configuration target: FSM encoding,
// command byte layout and register map.
package dfb_cfg_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE = 3'd0,
    ST_IDLE      = 3'd1,
    ST_CMD       = 3'd2,
    ST_DATA      = 3'd3,
    ST_TRAIL     = 3'd4
  } spi_state_t;

  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_RSVD_MSB = 6;
  localparam int CMD_RSVD_LSB = 2;
  localparam int CMD_ADDR_LSB = 0;

  localparam logic [1:0] REG_ID   = 2'd0;
  localparam logic [1:0] REG_CFG  = 2'd1;
  localparam logic [1:0] REG_SPI  = 2'd2;
  localparam logic [1:0] REG_USER = 2'd3;

endpackage

// File: rtl/spi_target_sync.sv
// Multi-flop synchroniser plus one-cycle rise/fall detector for one SPI pin.
// The chain resets low: for CS_N this reads as "frame in progress" until the
// real pin level arrives, so a frame already running at reset release never
// produces a spurious falling edge.
module spi_target_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLKOSC,
  input  logic RST,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // synchroniser chain and delayed copy for edge detection
  always_ff @(posedge CLKOSC or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target giving a host read/write access to a 4-entry config
// register file. All SPI pins are oversampled in the CLKOSC domain.
// Optional: define SPI_TARGET_AUTOINC_EN for burst access with address
// auto-increment (3 wraps to 0) instead of a single data byte.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_WAIT_IDLE | after reset, wait for CS_N high (ignore frame in flight)
// ST_IDLE      | no frame; CS_N fall starts one
// ST_CMD       | shifting in command byte, shifting out ID_VALUE
// ST_DATA      | data byte(s): write to or read from reg[addr]
// ST_TRAIL     | frame done; MISO sends 1s until CS_N rises
module spi_target
  import dfb_cfg_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_VALUE    = 8'h01,
  parameter logic [7:0] REG1_RESET  = 8'hFD,
  parameter logic [7:0] REG2_RESET  = 8'hFF,
  parameter logic [7:0] REG3_RESET  = 8'h00
) (
  input  logic       CLKOSC,
  input  logic       RST,
  input  logic       SPI_SCK,
  input  logic       SPI_CS_N,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  output logic       SPI_MISO_OE,
  output logic [7:0] REG1,
  output logic [7:0] REG2,
  output logic [7:0] REG3,
  output logic       WR_STROBE,
  output logic [1:0] WR_ADDR,
  output logic       BUSY
);

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic [2:0] unused_sync;

  spi_target_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .CLKOSC(CLKOSC), .RST(RST), .din(SPI_SCK),
    .q(sck_s), .rise(sck_rise), .fall(sck_fall)
  );

  spi_target_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .CLKOSC(CLKOSC), .RST(RST), .din(SPI_CS_N),
    .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_target_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .CLKOSC(CLKOSC), .RST(RST), .din(SPI_MOSI),
    .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync = {sck_s, mosi_rise, mosi_fall};

  spi_state_t state_q, state_d;
  logic [7:0] shift_q;
  logic [6:0] rx_q;
  logic [2:0] bit_cnt_q;
  logic [1:0] addr_q;
  logic       cmd_ok_q, cmd_rd_q;
  logic       miso_q, oe_q;
  logic       wr_strobe_q;
  logic [1:0] wr_addr_q;
  logic [7:0] reg1_q, reg2_q, reg3_q;

  logic [7:0] rx_byte;
  logic       byte_end;
  logic       cmd_ok_d;
  logic [1:0] cmd_addr;
  logic       wr_hit;

  assign rx_byte  = {rx_q, mosi_s};
  assign byte_end = sck_rise && (bit_cnt_q == 3'd7);
  assign cmd_ok_d = (rx_byte[CMD_RSVD_MSB:CMD_RSVD_LSB] == '0);
  assign cmd_addr = rx_byte[CMD_ADDR_LSB +: 2];
  assign wr_hit   = (state_q == ST_DATA) && byte_end && cmd_ok_q &&
                    !cmd_rd_q && (addr_q != REG_ID);

  function automatic logic [7:0] reg_rd(input logic [1:0] a);
    case (a)
      REG_ID:  reg_rd = ID_VALUE;
      REG_CFG: reg_rd = reg1_q;
      REG_SPI: reg_rd = reg2_q;
      default: reg_rd = reg3_q;
    endcase
  endfunction

  // FSM state register
  always_ff @(posedge CLKOSC or posedge RST) begin
    if (RST) state_q <= ST_WAIT_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic; CS_N rise overrides any concurrent SCK event
  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_WAIT_IDLE: if (cs_s) state_d = ST_IDLE;
        ST_IDLE:      if (cs_fall) state_d = ST_CMD;
        ST_CMD:       if (byte_end) state_d = ST_DATA;
`ifdef SPI_TARGET_AUTOINC_EN
        ST_DATA:      state_d = ST_DATA;
`else
        ST_DATA:      if (byte_end) state_d = ST_TRAIL;
`endif
        ST_TRAIL:     state_d = ST_TRAIL;
        default:      state_d = ST_WAIT_IDLE;
      endcase
    end
  end

  // shifters, command latch, register file and write strobe
  always_ff @(posedge CLKOSC or posedge RST) begin
    if (RST) begin
      miso_q      <= 1'b1;
      oe_q        <= 1'b0;
      shift_q     <= 8'hFF;
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      addr_q      <= '0;
      cmd_ok_q    <= 1'b0;
      cmd_rd_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      reg1_q      <= REG1_RESET;
      reg2_q      <= REG2_RESET;
      reg3_q      <= REG3_RESET;
    end else begin
      wr_strobe_q <= 1'b0;
      if (cs_rise) begin
        oe_q      <= 1'b0;
        miso_q    <= 1'b1;
        bit_cnt_q <= '0;
      end else if (state_q == ST_IDLE) begin
        if (cs_fall) begin
          oe_q      <= 1'b1;
          miso_q    <= ID_VALUE[7];
          shift_q   <= {ID_VALUE[6:0], 1'b1};
          bit_cnt_q <= '0;
        end
      end else if (state_q inside {ST_CMD, ST_DATA, ST_TRAIL}) begin
        if (sck_rise) begin
          rx_q      <= rx_byte[6:0];
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (byte_end) begin
            if (state_q == ST_CMD) begin
              cmd_ok_q <= cmd_ok_d;
              cmd_rd_q <= rx_byte[CMD_RW_BIT];
              addr_q   <= cmd_addr;
              shift_q  <= (cmd_ok_d && rx_byte[CMD_RW_BIT]) ? reg_rd(cmd_addr) : 8'hFF;
            end else if (state_q == ST_DATA) begin
              if (wr_hit) begin
                case (addr_q)
                  REG_CFG: reg1_q <= rx_byte;
                  REG_SPI: reg2_q <= rx_byte;
                  default: reg3_q <= rx_byte;
                endcase
                wr_strobe_q <= 1'b1;
                wr_addr_q   <= addr_q;
              end
`ifdef SPI_TARGET_AUTOINC_EN
              addr_q  <= addr_q + 2'd1;
              shift_q <= (cmd_ok_q && cmd_rd_q) ? reg_rd(addr_q + 2'd1) : 8'hFF;
`else
              shift_q <= 8'hFF;
`endif
            end else begin
              shift_q <= 8'hFF;
            end
          end
        end else if (sck_fall) begin
          miso_q  <= shift_q[7];
          shift_q <= {shift_q[6:0], 1'b1};
        end
      end
    end
  end

  assign SPI_MISO    = miso_q;
  assign SPI_MISO_OE = oe_q & ~cs_s;
  assign REG1        = reg1_q;
  assign REG2        = reg2_q;
  assign REG3        = reg3_q;
  assign WR_STROBE   = wr_strobe_q;
  assign WR_ADDR     = wr_addr_q;
  assign BUSY        = ~cs_s & (state_q != ST_WAIT_IDLE);

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: stimulus pushes expected MISO bytes and
// expected register writes; independent monitors pop and compare.
module tb_spi_target;

  localparam int HALF = 5;

  logic       CLKOSC = 1'b0;
  logic       RST;
  logic       SPI_SCK, SPI_CS_N, SPI_MOSI;
  logic       SPI_MISO, SPI_MISO_OE;
  logic [7:0] REG1, REG2, REG3;
  logic       WR_STROBE;
  logic [1:0] WR_ADDR;
  logic       BUSY;

  int n_vec = 0;
  int n_err = 0;
  logic mon_en = 1'b1;

  logic [7:0] exp_miso[$];
  logic [9:0] exp_wr[$];

  spi_target dut (
    .CLKOSC(CLKOSC), .RST(RST), .SPI_SCK(SPI_SCK), .SPI_CS_N(SPI_CS_N),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .SPI_MISO_OE(SPI_MISO_OE),
    .REG1(REG1), .REG2(REG2), .REG3(REG3), .WR_STROBE(WR_STROBE),
    .WR_ADDR(WR_ADDR), .BUSY(BUSY)
  );

  always #5 CLKOSC = ~CLKOSC;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge CLKOSC);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      SPI_MOSI = b[i];
      clk_wait(HALF);
      SPI_SCK = 1'b1;
      clk_wait(HALF);
      SPI_SCK = 1'b0;
    end
  endtask

  task automatic cs_low();
    SPI_CS_N = 1'b0;
    clk_wait(6);
    chk("busy_in_frame", {31'b0, BUSY}, 32'd1);
    chk("oe_in_frame", {31'b0, SPI_MISO_OE}, 32'd1);
  endtask

  task automatic cs_high();
    clk_wait(HALF);
    SPI_CS_N = 1'b1;
    clk_wait(10);
  endtask

  // MISO monitor: assemble a byte over 8 SCK rises and compare with scoreboard
  int         mon_cnt = 0;
  logic [7:0] mon_byte = '0;
  always @(posedge SPI_SCK or posedge SPI_CS_N) begin
    if (SPI_CS_N) begin
      mon_cnt = 0;
    end else if (mon_en) begin
      mon_byte = {mon_byte[6:0], SPI_MISO};
      mon_cnt++;
      if (mon_cnt == 8) begin
        mon_cnt = 0;
        if (exp_miso.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL miso_unexpected: got %h expected none", mon_byte);
        end else begin
          chk("miso_byte", {24'b0, mon_byte}, {24'b0, exp_miso.pop_front()});
        end
      end
    end
  end

  // write monitor: every strobe must match the next expected write
  always @(negedge CLKOSC) begin
    if (WR_STROBE === 1'b1) begin
      if (exp_wr.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL wr_unexpected: got addr %0d expected none", WR_ADDR);
      end else begin
        logic [9:0] e;
        logic [7:0] v;
        e = exp_wr.pop_front();
        case (WR_ADDR)
          2'd1: v = REG1;
          2'd2: v = REG2;
          2'd3: v = REG3;
          default: v = 8'hXX;
        endcase
        chk("wr_addr", {30'b0, WR_ADDR}, {30'b0, e[9:8]});
        chk("wr_data", {24'b0, v}, {24'b0, e[7:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; SPI_SCK = 1'b0; SPI_CS_N = 1'b1; SPI_MOSI = 1'b0;
    clk_wait(3);
    RST = 1'b0;
    clk_wait(10);
    chk("rst_reg1", {24'b0, REG1}, 32'hFD);
    chk("rst_reg2", {24'b0, REG2}, 32'hFF);
    chk("rst_reg3", {24'b0, REG3}, 32'h00);
    chk("rst_oe", {31'b0, SPI_MISO_OE}, 32'd0);
    chk("rst_busy", {31'b0, BUSY}, 32'd0);
    chk("rst_miso", {31'b0, SPI_MISO}, 32'd1);

    // read ID register
    exp_miso.push_back(8'h01); exp_miso.push_back(8'h01);
    cs_low(); spi_bits(8'h80, 8); spi_bits(8'h00, 8); cs_high();

    // write REG2 then read it back
    exp_miso.push_back(8'h01); exp_miso.push_back(8'hFF);
    exp_wr.push_back({2'd2, 8'h3C});
    cs_low(); spi_bits(8'h02, 8); spi_bits(8'h3C, 8); cs_high();
    chk("reg2_written", {24'b0, REG2}, 32'h3C);
    exp_miso.push_back(8'h01); exp_miso.push_back(8'h3C);
    cs_low(); spi_bits(8'h82, 8); spi_bits(8'h00, 8); cs_high();

    // aborted write after 5 data bits
    exp_miso.push_back(8'h01);
    cs_low(); spi_bits(8'h01, 8); spi_bits(8'hA5, 5); cs_high();
    chk("abort_reg1", {24'b0, REG1}, 32'hFD);
    chk("abort_oe", {31'b0, SPI_MISO_OE}, 32'd0);

    // full write to REG1 after the abort
    exp_miso.push_back(8'h01); exp_miso.push_back(8'hFF);
    exp_wr.push_back({2'd1, 8'hA5});
    cs_low(); spi_bits(8'h01, 8); spi_bits(8'hA5, 8); cs_high();
    chk("reg1_written", {24'b0, REG1}, 32'hA5);

    // reserved bit set, and write to address 0
    exp_miso.push_back(8'h01); exp_miso.push_back(8'hFF);
    cs_low(); spi_bits(8'h44, 8); spi_bits(8'h00, 8); cs_high();
    exp_miso.push_back(8'h01); exp_miso.push_back(8'hFF);
    cs_low(); spi_bits(8'h00, 8); spi_bits(8'h55, 8); cs_high();
    chk("rsvd_reg1", {24'b0, REG1}, 32'hA5);
    chk("rsvd_reg2", {24'b0, REG2}, 32'h3C);
    chk("rsvd_reg3", {24'b0, REG3}, 32'h00);

    // read REG1 with a third byte: trailer 1s or next register in burst mode
    exp_miso.push_back(8'h01); exp_miso.push_back(8'hA5);
`ifdef SPI_TARGET_AUTOINC_EN
    exp_miso.push_back(8'h3C);
`else
    exp_miso.push_back(8'hFF);
`endif
    cs_low(); spi_bits(8'h81, 8); spi_bits(8'h00, 8); spi_bits(8'h00, 8); cs_high();

    exp_miso.push_back(8'h01); exp_miso.push_back(8'h00);
    cs_low(); spi_bits(8'h83, 8); spi_bits(8'hFF, 8); cs_high();

    // reset in the middle of a frame with CS_N held low
    mon_en = 1'b0;
    SPI_CS_N = 1'b0;
    clk_wait(6);
    spi_bits(8'h03, 4);
    RST = 1'b1;
    clk_wait(2);
    chk("midrst_reg1", {24'b0, REG1}, 32'hFD);
    chk("midrst_reg2", {24'b0, REG2}, 32'hFF);
    chk("midrst_miso", {31'b0, SPI_MISO}, 32'd1);
    chk("midrst_oe", {31'b0, SPI_MISO_OE}, 32'd0);
    chk("midrst_busy", {31'b0, BUSY}, 32'd0);
    RST = 1'b0;
    clk_wait(6);
    spi_bits(8'h03, 8); spi_bits(8'h77, 8);
    chk("stale_reg3", {24'b0, REG3}, 32'h00);
    chk("stale_busy", {31'b0, BUSY}, 32'd0);
    chk("stale_oe", {31'b0, SPI_MISO_OE}, 32'd0);
    SPI_CS_N = 1'b1;
    clk_wait(10);
    mon_en = 1'b1;

    exp_miso.push_back(8'h01); exp_miso.push_back(8'hFF);
    cs_low(); spi_bits(8'h82, 8); spi_bits(8'h00, 8); cs_high();

    // multi-byte write frame
`ifdef SPI_TARGET_AUTOINC_EN
    exp_miso.push_back(8'h01); exp_miso.push_back(8'hFF);
    exp_miso.push_back(8'hFF); exp_miso.push_back(8'hFF);
    exp_wr.push_back({2'd1, 8'h11});
    exp_wr.push_back({2'd2, 8'h22});
    exp_wr.push_back({2'd3, 8'h33});
    cs_low();
    spi_bits(8'h01, 8); spi_bits(8'h11, 8); spi_bits(8'h22, 8); spi_bits(8'h33, 8);
    cs_high();
    chk("burst_reg1", {24'b0, REG1}, 32'h11);
    chk("burst_reg2", {24'b0, REG2}, 32'h22);
    chk("burst_reg3", {24'b0, REG3}, 32'h33);
`else
    exp_miso.push_back(8'h01); exp_miso.push_back(8'hFF); exp_miso.push_back(8'hFF);
    exp_wr.push_back({2'd1, 8'h11});
    cs_low(); spi_bits(8'h01, 8); spi_bits(8'h11, 8); spi_bits(8'h22, 8); cs_high();
    chk("trail_reg1", {24'b0, REG1}, 32'h11);
    chk("trail_reg2", {24'b0, REG2}, 32'hFF);
`endif

    clk_wait(10);
    chk("miso_queue_drained", exp_miso.size(), 32'd0);
    chk("wr_queue_drained", exp_wr.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI mode-0 responder (target) clocked by CLKOSC; the counterpart of the board's SPI master.
- Lets an external SPI host, such as a test jig or programming header, read and write a small configuration register file.
- The register contents drive board configuration (speed/ROM/FPU option mirror).
- Every SPI input is oversampled and synchronised into the CLKOSC domain; no logic is clocked by SCK.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on SCK/CS_N/MOSI (minimum 2).
- ID_VALUE, 8'h01, read-only contents of register 0; also shifted out during the command byte.
- REG1_RESET, 8'hFD, reset value of register 1 (config mirror).
- REG2_RESET, 8'hFF, reset value of register 2.
- REG3_RESET, 8'h00, reset value of register 3.

Ports:
- CLKOSC  in  1  system clock, oversampling clock.
- RST  in  1  reset, asynchronous, active-high.
- SPI_SCK  in  1  host serial clock; idle low (mode 0); frequency <= CLKOSC/4.
- SPI_CS_N  in  1  host chip select, active low.
- SPI_MOSI  in  1  host-to-target data, MSB first.
- SPI_MISO  out  1  target-to-host data.
- SPI_MISO_OE  out  1  MISO output enable; high only while CS_N is synchronised low.
- REG1  out  8  register 1 contents.
- REG2  out  8  register 2 contents.
- REG3  out  8  register 3 contents.
- WR_STROBE  out  1  one-cycle pulse when a register is written.
- WR_ADDR  out  2  address of the write; valid while WR_STROBE is high.
- BUSY  out  1  high while a frame is in progress (CS_N low after synchronisation).

Behaviour:
- Reset (async, RST=1):
  - REGn loads REGn_RESET.
  - SPI_MISO=1, SPI_MISO_OE=0, WR_STROBE=0, WR_ADDR=0, BUSY=0.
  - FSM goes to WAIT_IDLE; bit counter cleared.
- Synchronisation and edge detection:
  - SCK, CS_N and MOSI pass through SYNC_STAGES flops.
  - One further flop on each signal gives rise/fall detection.
  - All edge events are single-cycle CLKOSC pulses.
- FSM states:
  - WAIT_IDLE: wait for synchronised CS_N high, then go to IDLE. A frame already in progress at reset release is ignored.
  - IDLE: on CS_N fall go to CMD; load shifter with ID_VALUE; SPI_MISO = ID_VALUE[7]; SPI_MISO_OE=1.
  - CMD: sample MOSI on SCK rise; shift MISO on SCK fall. After the 8th rise, latch the command byte:
    - bit7 = R/W, 1 = read;
    - bits6:2 reserved, must be 0;
    - bits1:0 = address.
    - Then go to DATA. On the same cycle load the shifter with reg[addr] for a valid read, or 8'hFF for a write or invalid command.
  - DATA: 8 more bits. After the 8th rise:
    - valid write to addr 1-3: register updated, WR_STROBE=1 and WR_ADDR=addr for exactly one cycle, on the cycle after the synchronised 8th rise;
    - then go to TRAIL.
  - TRAIL: MISO shifts 8'hFF; MOSI is ignored; stay here until CS_N rises.
- CS_N rise in any state: return to IDLE; SPI_MISO_OE=0; SPI_MISO=1; bit counter cleared. A partial byte is discarded and no write occurs.
- Write to address 0: ignored, no strobe. Reserved command bits nonzero: whole frame ignored, MISO returns 8'hFF.
- Bit counter: 3 bits, wraps 7->0 at each byte boundary.
- Simultaneous SCK edge and CS_N rise: CS_N wins.
- Latency:
  - MISO bit changes within SYNC_STAGES+2 CLKOSC cycles of the SCK fall.
  - First MISO bit is valid SYNC_STAGES+2 cycles after the CS_N fall; the host must wait at least 4 CLKOSC cycles before the first SCK rise.
- BUSY equals synchronised ~CS_N, gated low in WAIT_IDLE.

Optional Feature:
- Macro: SPI_TARGET_AUTOINC_EN.
- Defined:
  - after each DATA byte, address increments by 1, wrapping 3->0;
  - FSM stays in DATA, so bursts read or write consecutive registers;
  - each completed write byte produces its own strobe.
- Undefined: behaviour is as above (single data byte, then TRAIL).

Decomposition:
- Shared package dfb_cfg_pkg, containing:
  - FSM state encoding;
  - command bit positions (CMD_RW_BIT=7, CMD_ADDR_LSB=0);
  - register addresses (REG_ID=0, REG_CFG=1, REG_SPI=2, REG_USER=3).
- One sub-module: spi_target_sync. It holds the SYNC_STAGES synchroniser plus edge detector, and is instantiated once per SCK/CS_N/MOSI.

Test Plan:
- Reset then idle: REG1=FD, REG2=FF, REG3=00, MISO_OE=0, BUSY=0.
- Frame cmd 8'h80 (read addr 0): MISO returns 8'h01 during the command byte and 8'h01 during the data byte; no strobe.
- Frame cmd 8'h02, data 8'h3C: REG2=8'h3C; one WR_STROBE with WR_ADDR=2. A following read with cmd 8'h82 returns 8'h3C.
- Write cmd 8'h01, CS_N raised after 5 data bits: REG1 stays FD; no strobe; the next full frame works normally.
- Cmd 8'h44 (reserved bit set) with data 8'h00: MISO returns FF; no register change. Cmd 8'h00 with data 8'h55: no change, no strobe.
- RST pulsed mid-frame with CS_N held low: outputs return to reset values; further SCK is ignored until CS_N goes high then low. With SPI_TARGET_AUTOINC_EN, cmd 8'h01 followed by data 11,22,33 gives REG1=11, REG2=22, REG3=33 and three strobes.
